mem_port_arbiter: RTL

Shares the single unified memory port between instruction fetch (F stage) and load/store accesses from the memory stage (M stage). It sequences each access as a held request/acknowledge transaction and generates the stall signals that freeze the pipeline registers until the access completes. It holds the last fetched word in a one-entry buffer so that a completed fetch is not lost while the front end is frozen.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/mem_port_arbiter_fetch_buffer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified memory port: arbiter states and ResultSrc encodings.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    FETCH = 2'b10
  } arb_state_t;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  function automatic logic is_data_access(input logic mem_write, input logic [1:0] result_src);
    return mem_write | (result_src == RESULT_MEM);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fetch_buffer.sv
// One-entry fetch buffer: keeps the last fetched word and its address so a frozen front end can re-read it.
module fetch_buffer
  import riscv_mem_pkg::*;
#(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill_en,
  input  logic [word_width-1:0] fill_tag,
  input  logic [word_width-1:0] fill_data,
  input  logic [word_width-1:0] lookup_addr,
  output logic                  hit,
  output logic [word_width-1:0] buf_data
);

  logic                  valid_r;
  logic [word_width-1:0] tag_r;
  logic [word_width-1:0] data_r;

  // Capture the completed fetch word together with its address tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      tag_r   <= {word_width{1'b0}};
      data_r  <= {word_width{1'b0}};
    end else if (fill_en) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag;
      data_r  <= fill_data;
    end
  end

  assign hit      = valid_r && (tag_r == lookup_addr);
  assign buf_data = data_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and M-stage loads/stores, with pipeline stalls.
// Build option: define MEM_ARB_TIMEOUT_EN to enable the ack watchdog and the sticky bus_error flag.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int word_width     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [word_width-1:0] if_addr,
  output logic [word_width-1:0] if_rdata,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] WriteDataM,
  output logic [word_width-1:0] ReadDataM,
  output logic                  stall_fetch,
  output logic                  stall_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [word_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [word_width-1:0] mem_rdata,
  output logic                  bus_error
);

  arb_state_t            state_r, state_nx_s;
  logic                  mem_req_r, mem_req_nx_s;
  logic                  mem_we_r, mem_we_nx_s;
  logic [word_width-1:0] mem_addr_r, mem_addr_nx_s;
  logic [word_width-1:0] mem_wdata_r, mem_wdata_nx_s;
  logic [word_width-1:0] load_r, buf_data_s, rdata_s;
  logic                  pending_s, hit_s, ack_s, timeout_s, done_s;
  logic                  fetch_done_s, data_done_s;

  assign pending_s    = is_data_access(MemWriteM, ResultSrcM);
  assign ack_s        = mem_ack & mem_req_r;
  assign done_s       = ack_s | timeout_s;
  assign rdata_s      = timeout_s ? {word_width{1'b0}} : mem_rdata;
  assign fetch_done_s = (state_r == FETCH) && done_s;
  assign data_done_s  = (state_r == DATA) && done_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             bus_error_r;

  assign timeout_s = mem_req_r & ~ack_s & (tmo_cnt_r == TMO_LAST);

  // Count unacknowledged cycles of the transaction currently on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (!mem_req_r || done_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_error_r <= 1'b0;
    end else if (timeout_s) begin
      bus_error_r <= 1'b1;
    end
  end

  assign bus_error = bus_error_r;
`else
  // Watchdog compiled out: a transaction waits for its ack indefinitely.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
  assign bus_error = 1'b0;
`endif

  fetch_buffer #(.word_width(word_width)) u_fetch_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .fill_en     (fetch_done_s),
    .fill_tag    (mem_addr_r),
    .fill_data   (rdata_s),
    .lookup_addr (if_addr),
    .hit         (hit_s),
    .buf_data    (buf_data_s)
  );

  // Next-state and next port request; data accesses win over fetches.
  always_comb begin
    state_nx_s     = state_r;
    mem_req_nx_s   = mem_req_r;
    mem_we_nx_s    = mem_we_r;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (pending_s) begin
          state_nx_s     = DATA;
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = MemWriteM;
          mem_addr_nx_s  = ALUResultM;
          mem_wdata_nx_s = WriteDataM;
        end else if (if_req && !hit_s) begin
          state_nx_s     = FETCH;
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = 1'b0;
          mem_addr_nx_s  = if_addr;
          mem_wdata_nx_s = {word_width{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end
      FETCH: begin
        // A waiting data access takes the port straight away, keeping mem_req high.
        if (ack_s && pending_s) begin
          state_nx_s     = DATA;
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = MemWriteM;
          mem_addr_nx_s  = ALUResultM;
          mem_wdata_nx_s = WriteDataM;
        end else if (done_s) begin
          state_nx_s   = IDLE;
          mem_req_nx_s = 1'b0;
        end else begin
          state_nx_s = FETCH;
        end
      end
      DATA: begin
        if (done_s) begin
          state_nx_s   = IDLE;
          mem_req_nx_s = 1'b0;
        end else begin
          state_nx_s = DATA;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        mem_req_nx_s = 1'b0;
      end
    endcase
  end

  // State and registered memory request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {word_width{1'b0}};
      mem_wdata_r <= {word_width{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      mem_req_r   <= mem_req_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
    end
  end

  // Hold the last load result for the M stage once the port moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_r <= {word_width{1'b0}};
    end else if (data_done_s && !mem_we_r) begin
      load_r <= rdata_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  assign if_rdata  = fetch_done_s ? rdata_s : buf_data_s;
  assign ReadDataM = data_done_s ? rdata_s : load_r;
  assign stall_mem = pending_s && !data_done_s;
  // A completing fetch only releases F when it is for the address F is asking for now.
  assign stall_fetch = if_req && !hit_s && !(fetch_done_s && (mem_addr_r == if_addr));

endmodule
